// File: rtl/io_mmio_ctrl.sv
// io_mmio_ctrl: memory-mapped board I/O between the CPU load/store stage and
// the board pins. Owns HEX0/HEX1 and LEDR, synchronizes and debounces KEY, and
// keeps sticky write-1-to-clear key-press and overrun flags.
// Ports:
//   CLOCK_50, RESET_N          clock, synchronous active-low reset
//   wr_en, rd_en, addr, wdata  CPU store/load strobes, byte address, store data
//   rdata, rd_valid            registered load data and its one-cycle qualifier
//   KEY                        raw active-low push-buttons (asynchronous)
//   HEX0, HEX1, LEDR           registered display and LED pin drive
module io_mmio_ctrl #(
  parameter int unsigned       DBITS           = 32,
  parameter logic [DBITS-1:0]  ADDR_HEX        = 32'hFFFF_0000,
  parameter logic [DBITS-1:0]  ADDR_LEDR       = 32'hFFFF_0020,
  parameter logic [DBITS-1:0]  ADDR_KEY        = 32'hFFFF_0080,
  parameter logic [DBITS-1:0]  ADDR_KEYCTL     = 32'hFFFF_0084,
  parameter int unsigned       DEBOUNCE_CYCLES = 16,
  parameter bit                SEG_DECODE      = 1'b1
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata,
  output logic             rd_valid,
  input  logic [3:0]       KEY,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [9:0]       LEDR
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Nibble to pin code: active-low gfedcba font, or raw nibble for simulation.
  function automatic logic [6:0] hex_enc(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return SEG_DECODE ? seg : {3'b000, n};
  endfunction

  logic [7:0]       hex_val_q, hex_val_d;
  logic [9:0]       led_val_q, led_val_d;
  logic [6:0]       hex0_q, hex1_q;
  logic [9:0]       ledr_q;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic             rd_valid_q;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       stable_q, stable_d;
  logic [CW-1:0]    cnt_q [4];
  logic [CW-1:0]    cnt_d [4];
  logic [3:0]       pressed_prev_q;
  logic [3:0]       press_q, press_d;
  logic [3:0]       ovr_q, ovr_d;

  logic [3:0]       pressed_c, rise_c;
  logic [7:0]       clr_c;
  logic             unused_wdata_c;

  assign unused_wdata_c = ^wdata[DBITS-1:10];

  // Next-state: register writes, debounce, sticky flags, load data.
  always_comb begin
    hex_val_d = hex_val_q;
    led_val_d = led_val_q;
    stable_d  = stable_q;
    rdata_d   = rdata_q;
    for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];

    if (wr_en && addr == ADDR_HEX)  hex_val_d = wdata[7:0];
    if (wr_en && addr == ADDR_LEDR) led_val_d = wdata[9:0];

    // Mismatches are counted off the first stage for latency; the flip is
    // committed only when the resolved second stage agrees as well.
    for (int i = 0; i < 4; i++) begin
      if (sync1_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST && sync2_q[i] != stable_q[i]) begin
          stable_d[i] = ~stable_q[i];
          cnt_d[i]    = '0;
        end else if (cnt_q[i] != CNT_LAST) begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end

    pressed_c = ~stable_q;
    rise_c    = pressed_c & ~pressed_prev_q;
    clr_c     = (wr_en && addr == ADDR_KEYCTL) ? wdata[7:0] : 8'h00;
    // Set beats clear on the same bit.
    press_d   = (press_q & ~clr_c[3:0]) | rise_c;
    ovr_d     = (ovr_q & ~clr_c[7:4]) | (rise_c & press_q);

    // Loads see pre-write register values.
    if (rd_en) begin
      if (addr == ADDR_HEX)         rdata_d = DBITS'(hex_val_q);
      else if (addr == ADDR_LEDR)   rdata_d = DBITS'(led_val_q);
      else if (addr == ADDR_KEY)    rdata_d = DBITS'(pressed_c);
      else if (addr == ADDR_KEYCTL) rdata_d = DBITS'({ovr_q, press_q});
      else                          rdata_d = '0;
    end
  end

  // State and pin registers.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      hex_val_q      <= '0;
      led_val_q      <= '0;
      hex0_q         <= hex_enc(4'h0);
      hex1_q         <= hex_enc(4'h0);
      ledr_q         <= '0;
      rdata_q        <= '0;
      rd_valid_q     <= 1'b0;
      sync1_q        <= '1;
      sync2_q        <= '1;
      stable_q       <= '1;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      pressed_prev_q <= '0;
      press_q        <= '0;
      ovr_q          <= '0;
    end else begin
      hex_val_q      <= hex_val_d;
      led_val_q      <= led_val_d;
      hex0_q         <= hex_enc(hex_val_q[3:0]);
      hex1_q         <= hex_enc(hex_val_q[7:4]);
      ledr_q         <= led_val_q;
      rdata_q        <= rdata_d;
      rd_valid_q     <= rd_en;
      sync1_q        <= KEY;
      sync2_q        <= sync1_q;
      stable_q       <= stable_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      pressed_prev_q <= pressed_c;
      press_q        <= press_d;
      ovr_q          <= ovr_d;
    end
  end

  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign HEX0     = hex0_q;
  assign HEX1     = hex1_q;
  assign LEDR     = ledr_q;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Bench for io_mmio_ctrl: directed spec scenarios followed by random traffic,
// every cycle compared against a behavioural model of the register map and
// a sample-window view of the debouncer.
module tb_io_mmio_ctrl;

  localparam int unsigned D = 16;
  localparam logic [31:0] A_HEX    = 32'hFFFF_0000;
  localparam logic [31:0] A_LEDR   = 32'hFFFF_0020;
  localparam logic [31:0] A_KEY    = 32'hFFFF_0080;
  localparam logic [31:0] A_KEYCTL = 32'hFFFF_0084;

  logic        clk = 1'b0;
  logic        RESET_N, wr_en, rd_en;
  logic [31:0] addr, wdata, rdata;
  logic        rd_valid;
  logic [3:0]  KEY;
  logic [6:0]  HEX0, HEX1;
  logic [9:0]  LEDR;

  always #10 clk = ~clk;

  io_mmio_ctrl #(
    .DBITS(32), .ADDR_HEX(A_HEX), .ADDR_LEDR(A_LEDR), .ADDR_KEY(A_KEY),
    .ADDR_KEYCTL(A_KEYCTL), .DEBOUNCE_CYCLES(D), .SEG_DECODE(1'b1)
  ) dut (
    .CLOCK_50(clk), .RESET_N(RESET_N), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rd_valid(rd_valid),
    .KEY(KEY), .HEX0(HEX0), .HEX1(HEX1), .LEDR(LEDR)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state.
  logic [7:0]  m_hex;
  logic [9:0]  m_led, m_ledr;
  logic [6:0]  m_hex0, m_hex1;
  logic [31:0] m_rdata;
  logic        m_rdv;
  logic [3:0]  m_stable, m_ps1, m_press, m_ovr;
  logic [3:0]  hist [$];   // KEY samples from the D most recent edges

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference: reads see pre-edge state, a key
  // becomes stable at value v once the last D samples were all v.
  task automatic model_step();
    logic [3:0]  ps0, rise, nst;
    logic [7:0]  clr;
    logic        flip;
    if (!RESET_N) begin
      m_hex = 8'h00; m_led = 10'h000; m_ledr = 10'h000;
      m_hex0 = font[0]; m_hex1 = font[0];
      m_rdata = 32'h0; m_rdv = 1'b0;
      m_stable = 4'hF; m_ps1 = 4'h0; m_press = 4'h0; m_ovr = 4'h0;
      hist.delete();
      for (int j = 0; j < int'(D); j++) hist.push_back(4'hF);
      return;
    end
    ps0 = ~m_stable;
    if (rd_en) begin
      if (addr == A_HEX)         m_rdata = {24'h0, m_hex};
      else if (addr == A_LEDR)   m_rdata = {22'h0, m_led};
      else if (addr == A_KEY)    m_rdata = {28'h0, ps0};
      else if (addr == A_KEYCTL) m_rdata = {24'h0, m_ovr, m_press};
      else                       m_rdata = 32'h0;
    end
    m_rdv  = rd_en;
    m_hex0 = font[m_hex[3:0]];
    m_hex1 = font[m_hex[7:4]];
    m_ledr = m_led;
    if (wr_en && addr == A_HEX)  m_hex = wdata[7:0];
    if (wr_en && addr == A_LEDR) m_led = wdata[9:0];
    clr  = (wr_en && addr == A_KEYCTL) ? wdata[7:0] : 8'h00;
    rise = ps0 & ~m_ps1;
    m_ovr   = (m_ovr & ~clr[7:4]) | (rise & m_press);
    m_press = (m_press & ~clr[3:0]) | rise;
    m_ps1   = ps0;
    nst = m_stable;
    for (int b = 0; b < 4; b++) begin
      flip = 1'b1;
      foreach (hist[j]) if (hist[j][b] == m_stable[b]) flip = 1'b0;
      if (flip) nst[b] = ~m_stable[b];
    end
    m_stable = nst;
    hist.push_back(KEY);
    void'(hist.pop_front());
  endtask

  // Drive one cycle of bus traffic, step the model at the edge, compare after.
  task automatic cycle(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] w);
    wr_en = wr; rd_en = rd; addr = a; wdata = w;
    @(posedge clk);
    model_step();
    #1;
    chk("HEX0", 32'(HEX0), 32'(m_hex0));
    chk("HEX1", 32'(HEX1), 32'(m_hex1));
    chk("LEDR", 32'(LEDR), 32'(m_ledr));
    chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
    chk("rdata", rdata, m_rdata);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  logic [31:0] addrs [5];

  initial begin
    addrs = '{A_HEX, A_LEDR, A_KEY, A_KEYCTL, A_KEY + 32'd8};
    RESET_N = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0; KEY = 4'hF;
    @(negedge clk);
    idle(3);
    chk("rst_hex0", 32'(HEX0), 32'h40);
    chk("rst_ledr", 32'(LEDR), 32'h0);
    chk("rst_rdv", 32'(rd_valid), 32'h0);
    RESET_N = 1'b1;

    // HEX write shows on pins two edges later.
    cycle(1'b1, 1'b0, A_HEX, 32'h0000_0001);
    idle(1);
    chk("hex0_one", 32'(HEX0), 32'h79);
    chk("hex1_zero", 32'(HEX1), 32'h40);

    // LEDR write/read and an unmapped read.
    cycle(1'b1, 1'b0, A_LEDR, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, A_LEDR, 32'h0);
    chk("ledr_rd", rdata, 32'h3FF);
    chk("ledr_rdv", 32'(rd_valid), 32'h1);
    chk("ledr_pin", 32'(LEDR), 32'h3FF);
    cycle(1'b0, 1'b1, A_KEY + 32'd8, 32'h0);
    chk("unmapped_rd", rdata, 32'h0);

    // 15-cycle glitch is filtered.
    KEY = 4'b1110; idle(15);
    KEY = 4'hF;    idle(20);
    cycle(1'b0, 1'b1, A_KEY, 32'h0);
    chk("glitch_key", rdata, 32'h0);
    cycle(1'b0, 1'b1, A_KEYCTL, 32'h0);
    chk("glitch_keyctl", rdata, 32'h0);

    // Long press: flag set at edge k+D+1, seen by the read sampled one edge later.
    KEY = 4'b1110;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b1, A_KEYCTL, 32'h0);
      if (i == int'(D) + 1) chk("press_edge_pre", rdata, 32'h0);
      if (i == int'(D) + 2) chk("press_edge_post", rdata, 32'h1);
    end
    cycle(1'b0, 1'b1, A_KEY, 32'h0);
    chk("key_held", rdata, 32'h1);
    KEY = 4'hF; idle(20);

    // Second press raises overrun; W1C of overrun only.
    KEY = 4'b1110; idle(20);
    KEY = 4'hF;    idle(20);
    cycle(1'b0, 1'b1, A_KEYCTL, 32'h0);
    chk("overrun", rdata, 32'h11);
    cycle(1'b1, 1'b0, A_KEYCTL, 32'h10);
    cycle(1'b0, 1'b1, A_KEYCTL, 32'h0);
    chk("clr_ovr", rdata, 32'h01);

    // Clear collides with a new press: set wins.
    KEY = 4'b1110;
    for (int i = 0; i < 25; i++) begin
      if (i == int'(D) + 1) cycle(1'b1, 1'b0, A_KEYCTL, 32'h01);
      else                  idle(1);
    end
    KEY = 4'hF; idle(20);
    cycle(1'b0, 1'b1, A_KEYCTL, 32'h0);
    chk("set_wins", rdata, 32'h11);

    // Same-cycle read and write returns the pre-write value.
    cycle(1'b1, 1'b0, A_HEX, 32'h3C);
    cycle(1'b1, 1'b1, A_HEX, 32'hA5);
    chk("rw_old", rdata, 32'h3C);
    cycle(1'b0, 1'b1, A_HEX, 32'h0);
    chk("rw_new", rdata, 32'hA5);

    // Reset at debounce count 10 with keys held; press reported D+2 edges later.
    cycle(1'b1, 1'b0, A_KEYCTL, 32'hFF);
    KEY = 4'h0; idle(11);
    RESET_N = 1'b0; idle(1);
    chk("mid_rst_hex0", 32'(HEX0), 32'h40);
    chk("mid_rst_hex1", 32'(HEX1), 32'h40);
    chk("mid_rst_ledr", 32'(LEDR), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    RESET_N = 1'b1;
    for (int j = 1; j <= 25; j++) begin
      cycle(1'b0, 1'b1, A_KEYCTL, 32'h0);
      if (j == int'(D) + 2) chk("post_rst_pre", rdata, 32'h0);
      if (j == int'(D) + 3) chk("post_rst_post", rdata, 32'h0F);
    end
    KEY = 4'hF; idle(20);

    // Random traffic and key activity against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) KEY = 4'($urandom);
      cycle(($urandom_range(0, 2) == 0), 1'($urandom), addrs[$urandom_range(0, 4)],
            $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
